// File: rtl/systolic_addr_gen.sv
// rtl/systolic_addr_gen.sv - read-address sequencer for the tiled systolic matrix-multiply datapath
// Walks (A slice, B slice, k) and issues one operand read beat per unstalled RUN cycle.
module systolic_addr_gen #(
   parameter int N1    = 4,
   parameter int N2    = 4,
   parameter int MA    = 8,
   parameter int K     = 8,
   parameter int PB    = 8,
   parameter int ORDER = 0,
   localparam int TA_N = MA / N1,
   localparam int TB_N = PB / N2,
   localparam int KW   = (K > 1) ? $clog2(K) : 1,
   localparam int TAW  = (TA_N > 1) ? $clog2(TA_N) : 1,
   localparam int TBW  = (TB_N > 1) ? $clog2(TB_N) : 1,
   localparam int AAW  = (TA_N * K > 1) ? $clog2(TA_N * K) : 1,
   localparam int ABW  = (TB_N * K > 1) ? $clog2(TB_N * K) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           stall,
   output logic           busy,
   output logic           done,
   output logic           rd_en,
   output logic [AAW-1:0] rd_addr_A,
   output logic [ABW-1:0] rd_addr_B,
   output logic [TAW-1:0] tile_A,
   output logic [TBW-1:0] tile_B,
   output logic           first_k,
   output logic           last_k
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [KW-1:0]  K_LAST  = KW'(K - 1);
   localparam logic [TAW-1:0] TA_LAST = TAW'(TA_N - 1);
   localparam logic [TBW-1:0] TB_LAST = TBW'(TB_N - 1);

   state_t         state, state_nx;
   logic [KW-1:0]  k;
   logic [TAW-1:0] ta;
   logic [TBW-1:0] tb;
   logic           beat, k_last, ta_last, tb_last, pass_end;

   assign beat     = (state == RUN) && !stall;
   assign k_last   = (k == K_LAST);
   assign ta_last  = (ta == TA_LAST);
   assign tb_last  = (tb == TB_LAST);
   assign pass_end = k_last && ta_last && tb_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (beat && pass_end) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Counters are cleared outside RUN so every pass begins at k=0, ta=0, tb=0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k  <= '0;
         ta <= '0;
         tb <= '0;
      end else if (state != RUN) begin
         k  <= '0;
         ta <= '0;
         tb <= '0;
      end else if (beat) begin
         if (!k_last) begin
            k <= k + 1'b1;
         end else begin
            k <= '0;
            if (ORDER == 0) begin
               tb <= tb_last ? '0 : tb + 1'b1;
               if (tb_last) ta <= ta_last ? '0 : ta + 1'b1;
            end else begin
               ta <= ta_last ? '0 : ta + 1'b1;
               if (ta_last) tb <= tb_last ? '0 : tb + 1'b1;
            end
         end
      end
   end

   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign rd_en     = beat;
   assign first_k   = beat && (k == '0);
   assign last_k    = beat && k_last;
   assign tile_A    = ta;
   assign tile_B    = tb;
   assign rd_addr_A = AAW'(ta) * AAW'(K) + AAW'(k);
   assign rd_addr_B = ABW'(tb) * ABW'(K) + ABW'(k);

endmodule

// File: tb/tb_systolic_addr_gen.sv
// tb/tb_systolic_addr_gen.sv - self-checking bench for systolic_addr_gen
// Three instances: default, ORDER=1, and a K=1 single-A-slice configuration.
module tb_systolic_addr_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, stall, start0, start1, start2;

   logic       busy0, done0, rd0, fk0, lk0;
   logic [3:0] aa0, ab0;
   logic [0:0] ta0, tb0;
   logic       busy1, done1, rd1, fk1, lk1;
   logic [3:0] aa1, ab1;
   logic [0:0] ta1, tb1;
   logic       busy2, done2, rd2, fk2, lk2;
   logic [0:0] aa2;
   logic [1:0] ab2;
   logic [0:0] ta2;
   logic [1:0] tb2;

   systolic_addr_gen #(.N1(4), .N2(4), .MA(8), .K(8), .PB(8), .ORDER(0)) u0 (
      .clk(clk), .rst(rst), .start(start0), .stall(stall), .busy(busy0), .done(done0),
      .rd_en(rd0), .rd_addr_A(aa0), .rd_addr_B(ab0), .tile_A(ta0), .tile_B(tb0),
      .first_k(fk0), .last_k(lk0));

   systolic_addr_gen #(.N1(4), .N2(4), .MA(8), .K(8), .PB(8), .ORDER(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .stall(stall), .busy(busy1), .done(done1),
      .rd_en(rd1), .rd_addr_A(aa1), .rd_addr_B(ab1), .tile_A(ta1), .tile_B(tb1),
      .first_k(fk1), .last_k(lk1));

   systolic_addr_gen #(.N1(4), .N2(2), .MA(4), .K(1), .PB(8), .ORDER(0)) u2 (
      .clk(clk), .rst(rst), .start(start2), .stall(stall), .busy(busy2), .done(done2),
      .rd_en(rd2), .rd_addr_A(aa2), .rd_addr_B(ab2), .tile_A(ta2), .tile_B(tb2),
      .first_k(fk2), .last_k(lk2));

   int          sel;
   logic [36:0] obs;

   // {busy, done, rd_en, first_k, last_k, addr_A, addr_B, tile_A, tile_B}, fields zero-extended to 8 bits
   always_comb begin
      obs = '0;
      case (sel)
         0: obs = {busy0, done0, rd0, fk0, lk0, 8'(aa0), 8'(ab0), 8'(ta0), 8'(tb0)};
         1: obs = {busy1, done1, rd1, fk1, lk1, 8'(aa1), 8'(ab1), 8'(ta1), 8'(tb1)};
         default: obs = {busy2, done2, rd2, fk2, lk2, 8'(aa2), 8'(ab2), 8'(ta2), 8'(tb2)};
      endcase
   end

   int checks = 0;
   int errors = 0;

   int q_ta[$], q_tb[$], q_k[$];
   int kk, total;
   int mstate, idx;
   int rd_seen, done_seen, busy_seen, run_stalls;

   task automatic check(input string tag, input logic [36:0] got, input logic [36:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int want);
      checks++;
      assert (got == want) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
      end
   endtask

   // Beat list for one pass, built directly from the nested tile loop order.
   task automatic build(input int s);
      int tan, tbn, ord;
      case (s)
         0:       begin tan = 2; tbn = 2; kk = 8; ord = 0; end
         1:       begin tan = 2; tbn = 2; kk = 8; ord = 1; end
         default: begin tan = 1; tbn = 4; kk = 1; ord = 0; end
      endcase
      sel = s;
      q_ta.delete(); q_tb.delete(); q_k.delete();
      for (int o = 0; o < (ord == 0 ? tan : tbn); o++)
         for (int i = 0; i < (ord == 0 ? tbn : tan); i++)
            for (int k = 0; k < kk; k++) begin
               q_ta.push_back(ord == 0 ? o : i);
               q_tb.push_back(ord == 0 ? i : o);
               q_k.push_back(k);
            end
      total = q_k.size();
   endtask

   function automatic logic [36:0] expected(input logic stall_v);
      logic run, rd;
      int   a, b, k;
      run = (mstate == 1);
      rd  = run && !stall_v;
      a = run ? q_ta[idx] : 0;
      b = run ? q_tb[idx] : 0;
      k = run ? q_k[idx]  : 0;
      return {run, mstate == 2, rd, rd && (k == 0), rd && (k == kk - 1),
              8'(k + a * kk), 8'(k + b * kk), 8'(a), 8'(b)};
   endfunction

   task automatic cycle(input logic st_v, input logic stall_v, input string tag);
      @(posedge clk);
      #1;
      start0 = st_v && (sel == 0);
      start1 = st_v && (sel == 1);
      start2 = st_v && (sel == 2);
      stall  = stall_v;
      @(negedge clk);
      check(tag, obs, expected(stall_v));
      if (obs[34]) rd_seen++;
      if (obs[35]) done_seen++;
      if (obs[36]) busy_seen++;
      case (mstate)
         0: if (st_v) begin mstate = 1; idx = 0; end
         1: begin
            if (stall_v) run_stalls++;
            else begin
               idx++;
               if (idx == total) mstate = 2;
            end
         end
         default: mstate = 0;
      endcase
   endtask

   // stall_mode: 0 none, 1 three cycles at beat 5, 2 random
   task automatic run_pass(input string tag, input int stall_mode, input bit extra);
      int   n, stalled;
      logic st_v, sv;
      n = 0; stalled = 0;
      rd_seen = 0; done_seen = 0; busy_seen = 0; run_stalls = 0;
      cycle(1'b1, 1'b0, tag);
      while (mstate != 0 && n < 400) begin
         st_v = extra && ((mstate == 1 && idx == 10 % total) || mstate == 2);
         sv = 1'b0;
         if (stall_mode == 1 && mstate == 1 && idx == 5 && stalled < 3) begin
            sv = 1'b1; stalled++;
         end else if (stall_mode == 2) begin
            sv = ($urandom_range(0, 3) == 0);
         end
         cycle(st_v, sv, tag);
         n++;
      end
      check_int({tag, "_bound"}, int'(n < 400), 1);
      check_int({tag, "_beats"}, rd_seen, total);
      check_int({tag, "_done"}, done_seen, 1);
      check_int({tag, "_busy_cycles"}, busy_seen, total + run_stalls);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      mstate = 0; idx = 0;
      build(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1 check("reset_outputs", obs, 37'd0);
      end
      sel = 0;
      rst = 1'b1;

      build(0);
      run_pass("default_pass", 0, 1'b0);
      run_pass("stall_at_k5", 1, 1'b0);
      run_pass("extra_starts", 0, 1'b1);
      run_pass("start_after_done", 0, 1'b0);

      // Abort a pass at beat 11 (k=3, tb=1) with an asynchronous reset.
      cycle(1'b1, 1'b0, "pre_reset");
      for (int n = 0; n < 40 && idx != 11; n++) cycle(1'b0, 1'b0, "pre_reset");
      check_int("pre_reset_reached", idx, 11);
      @(posedge clk);
      #2 check("at_k3_tb1", obs, expected(1'b0));
      rst = 1'b0;
      #1 check("async_reset", obs, 37'd0);
      mstate = 0;
      @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 4; n++) cycle(1'b0, 1'($urandom_range(0, 1)), "idle_after_reset");
      run_pass("pass_after_reset", 0, 1'b0);

      build(1);
      run_pass("order1_pass", 0, 1'b0);
      run_pass("order1_random", 2, 1'b1);

      build(2);
      run_pass("k1_pass", 0, 1'b0);
      run_pass("k1_random", 2, 1'b1);

      for (int r = 0; r < 6; r++) begin
         build($urandom_range(0, 2));
         for (int n = 0; n < int'($urandom_range(0, 3)); n++)
            cycle(1'b0, 1'($urandom_range(0, 1)), "random_idle");
         run_pass("random_pass", 2, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
